// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the RV32IM pipeline registers and the hazard controller.
// The pipeline side is the master (reports ID/EX contents); the controller is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 6
);
    // Instruction info reported by the pipeline
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_is_mul;
    logic             ex_is_div;
    logic             ex_branch_taken;

    // Per-cycle pipeline register controls
    logic             pc_write_en;
    logic             if_id_write_en;
    logic             if_id_flush;
    logic             id_ex_write_en;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mdu_busy;

    // Controller state visibility: dbg_state 0 = RUN, 1 = MDU_WAIT
    logic             dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_mem_read, ex_rd, ex_is_mul, ex_is_div, ex_branch_taken,
        input  pc_write_en, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_flush, mdu_busy,
               dbg_state, dbg_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_mem_read, ex_rd, ex_is_mul, ex_is_div, ex_branch_taken,
        output pc_write_en, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_flush, mdu_busy,
               dbg_state, dbg_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the RV32IM pipeline: load-use stalls, taken-branch
// flushes and multi-cycle MUL/DIV holds in EX.
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // The entry cycle in RUN is the first stall, so the counter covers the remaining N-2.
    localparam bit               DIV_MULTI = (DIV_CYCLES >= 2);
    localparam bit               MUL_MULTI = (MUL_CYCLES >= 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES >= 2 ? DIV_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_CYCLES >= 2 ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             load_use;
    logic             mdu_multi;
    logic [CNT_W-1:0] mdu_load;

    logic             pc_we;
    logic             if_id_we;
    logic             if_id_fl;
    logic             id_ex_we;
    logic             id_ex_fl;
    logic             ex_mem_fl;
    logic             busy;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    assign mdu_multi = hz.ex_is_div ? DIV_MULTI :
                       hz.ex_is_mul ? MUL_MULTI : 1'b0;
    assign mdu_load  = hz.ex_is_div ? DIV_LOAD :
                       hz.ex_is_mul ? MUL_LOAD : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        if_id_fl  = 1'b0;
        id_ex_we  = 1'b1;
        id_ex_fl  = 1'b0;
        ex_mem_fl = 1'b0;
        busy      = 1'b0;

        if (reset) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_we = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        if_id_fl = 1'b1;
                        id_ex_fl = 1'b1;
                    end else if (mdu_multi) begin
                        pc_we     = 1'b0;
                        if_id_we  = 1'b0;
                        id_ex_we  = 1'b0;
                        ex_mem_fl = 1'b1;
                        busy      = 1'b1;
                        cnt_nxt   = mdu_load;
                        state_nxt = MDU_WAIT;
                    end else if (load_use) begin
                        pc_we    = 1'b0;
                        if_id_we = 1'b0;
                        id_ex_fl = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    // Front-end events are frozen behind the MDU op; it resolves them after release.
                    if (cnt != '0) begin
                        pc_we     = 1'b0;
                        if_id_we  = 1'b0;
                        id_ex_we  = 1'b0;
                        ex_mem_fl = 1'b1;
                        busy      = 1'b1;
                        cnt_nxt   = cnt - CNT_ONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign hz.pc_write_en    = pc_we;
    assign hz.if_id_write_en = if_id_we;
    assign hz.if_id_flush    = if_id_fl;
    assign hz.id_ex_write_en = id_ex_we;
    assign hz.id_ex_flush    = id_ex_fl;
    assign hz.ex_mem_flush   = ex_mem_fl;
    assign hz.mdu_busy       = busy;
    assign hz.dbg_state      = state;
    assign hz.dbg_cnt        = cnt;

endmodule
